// File: rtl/pcie_tx_stream_arbiter_if.sv
// Stream bundle between the two TX sources, the arbiter and the 64-to-32 converter.
// master = environment side (drives sources, sinks the merged stream); slave = arbiter side.
interface pcie_tx_stream_arbiter_if;
  logic [63:0] i_s0_data;
  logic        i_s0_valid;
  logic        i_s0_last;
  logic        o_s0_ready;
  logic [63:0] i_s1_data;
  logic        i_s1_valid;
  logic        i_s1_last;
  logic        o_s1_ready;
  logic [63:0] o_64_data;
  logic        o_64_valid;
  logic        o_64_last;
  logic        i_64_ready;

  modport master (
    output i_s0_data, i_s0_valid, i_s0_last,
    input  o_s0_ready,
    output i_s1_data, i_s1_valid, i_s1_last,
    input  o_s1_ready,
    input  o_64_data, o_64_valid, o_64_last,
    output i_64_ready
  );

  modport slave (
    input  i_s0_data, i_s0_valid, i_s0_last,
    output o_s0_ready,
    input  i_s1_data, i_s1_valid, i_s1_last,
    output o_s1_ready,
    output o_64_data, o_64_valid, o_64_last,
    input  i_64_ready
  );
endinterface

// File: rtl/pcie_tx_stream_arbiter.sv
// Two-source packet arbiter feeding the 64-to-32 converter; round-robin ties, or source 0
// always wins ties when PCIE_TX_ARB_FIXED_PRIORITY_EN is defined. Data path is combinational.
module pcie_tx_stream_arbiter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_tx_stream_arbiter_if.slave bus,
  output logic [1:0]             o_grant,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_s0_pkt_count,
  output logic [COUNT_WIDTH-1:0] o_s1_pkt_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER0 = 2'b01,
    XFER1 = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   last_served;
  logic [COUNT_WIDTH-1:0] cnt0;
  logic [COUNT_WIDTH-1:0] cnt1;
  logic                   done0;
  logic                   done1;
  logic                   s0_wins_tie;

`ifdef PCIE_TX_ARB_FIXED_PRIORITY_EN
  assign s0_wins_tie = 1'b1;
`else
  // last_served==1 means source 1 went last, so source 0 is next in line.
  assign s0_wins_tie = last_served;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      cnt0        <= '0;
      cnt1        <= '0;
    end else begin
      state <= state_nxt;
      if (done0) begin
        last_served <= 1'b0;
        cnt0        <= cnt0 + COUNT_WIDTH'(1);
      end
      if (done1) begin
        last_served <= 1'b1;
        cnt1        <= cnt1 + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    done0          = 1'b0;
    done1          = 1'b0;
    bus.o_64_data  = '0;
    bus.o_64_valid = 1'b0;
    bus.o_64_last  = 1'b0;
    bus.o_s0_ready = 1'b0;
    bus.o_s1_ready = 1'b0;
    o_grant        = 2'b00;
    o_busy         = 1'b0;
    o_s0_pkt_count = cnt0;
    o_s1_pkt_count = cnt1;

    case (state)
      IDLE: begin
        if (bus.i_s0_valid && (!bus.i_s1_valid || s0_wins_tie))
          state_nxt = XFER0;
        else if (bus.i_s1_valid)
          state_nxt = XFER1;
      end
      XFER0: begin
        bus.o_64_data  = bus.i_s0_data;
        bus.o_64_valid = bus.i_s0_valid;
        bus.o_64_last  = bus.i_s0_last;
        bus.o_s0_ready = bus.i_64_ready;
        o_grant        = 2'b01;
        o_busy         = 1'b1;
        // Grant is only released by an accepted last beat, never by a valid gap.
        if (bus.i_s0_valid && bus.i_64_ready && bus.i_s0_last) begin
          state_nxt = IDLE;
          done0     = 1'b1;
        end
      end
      XFER1: begin
        bus.o_64_data  = bus.i_s1_data;
        bus.o_64_valid = bus.i_s1_valid;
        bus.o_64_last  = bus.i_s1_last;
        bus.o_s1_ready = bus.i_64_ready;
        o_grant        = 2'b10;
        o_busy         = 1'b1;
        if (bus.i_s1_valid && bus.i_64_ready && bus.i_s1_last) begin
          state_nxt = IDLE;
          done1     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset aborts any packet at once: every output reads zero and nothing is counted.
    if (rst) begin
      done0          = 1'b0;
      done1          = 1'b0;
      bus.o_64_data  = '0;
      bus.o_64_valid = 1'b0;
      bus.o_64_last  = 1'b0;
      bus.o_s0_ready = 1'b0;
      bus.o_s1_ready = 1'b0;
      o_grant        = 2'b00;
      o_busy         = 1'b0;
      o_s0_pkt_count = '0;
      o_s1_pkt_count = '0;
    end
  end

endmodule

// File: doc/pcie_tx_stream_arbiter.md
PCIE_TX_STREAM_ARBITER -- requirements
Module: pcie_tx_stream_arbiter

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 16, giving the width of the per-source packet counters.
REQ-002 The block SHALL have these ports, listed as name, direction, width and meaning:
  clk  input  1  single clock for all logic
  rst  input  1  synchronous, active-high reset
  i_s0_data  input  64  source 0 data
  i_s0_valid  input  1  source 0 beat valid
  i_s0_last  input  1  source 0 last beat of packet
  o_s0_ready  output  1  source 0 beat accepted
  i_s1_data / i_s1_valid / i_s1_last / o_s1_ready  as for source 0
  o_64_data  output  64  arbitrated data to the 64-to-32 converter
  o_64_valid  output  1  arbitrated beat valid
  o_64_last  output  1  arbitrated last beat
  i_64_ready  input  1  converter ready
  o_grant  output  2  one-hot owner, 2'b00 when idle
  o_busy  output  1  a packet is in progress
  o_s0_pkt_count  output  COUNT_WIDTH  completed source 0 packets
  o_s1_pkt_count  output  COUNT_WIDTH  completed source 1 packets
REQ-003 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 The state machine SHALL have three states: IDLE, XFER0 and XFER1.
REQ-005 In IDLE, o_64_valid and both ready outputs SHALL be 0.
REQ-006 In IDLE, if exactly one source has valid=1, that source SHALL be granted on the next clock edge.
REQ-007 In IDLE, if both sources are valid, the source that was not served last (last_served register) SHALL be granted.
REQ-008 In XFERn, o_64_data, o_64_valid and o_64_last SHALL combinationally equal source n's data, valid and last.
REQ-009 In XFERn, o_sn_ready SHALL equal i_64_ready, and the other source's ready SHALL be 0.
REQ-010 A beat SHALL transfer on a cycle where o_64_valid=1 and i_64_ready=1.
REQ-011 The grant SHALL be held until a beat transfers with last=1; a source dropping valid mid-packet SHALL NOT release the grant.
REQ-012 On the edge of the last-beat transfer, the state SHALL return to IDLE, last_served SHALL become n, and o_sn_pkt_count SHALL increment.
REQ-013 At least one idle cycle SHALL occur between packets, so arbitration latency is 1 cycle from IDLE with valid asserted to the first possible transfer.
REQ-014 A one-beat packet (valid and last together) SHALL complete in one XFER cycle.
REQ-015 Packet counters SHALL wrap modulo 2^COUNT_WIDTH with no saturation.
REQ-016 o_grant SHALL be 2'b01 in XFER0, 2'b10 in XFER1 and 2'b00 in IDLE; o_busy SHALL be 1 exactly when o_grant is not 0.
REQ-017 An undefined state encoding SHALL return to IDLE on the next edge.

Reset
REQ-018 When rst=1, the state SHALL become IDLE, o_grant 0, o_busy 0, both counters 0, and last_served 1 (so source 0 wins the first tie).
REQ-019 A reset applied mid-packet SHALL abort the packet immediately; no ready or valid SHALL be asserted while rst=1, and the aborted packet SHALL NOT be counted.
REQ-020 All outputs SHALL be 0 during reset, including o_64_data.

Configuration
REQ-021 With macro PCIE_TX_ARB_FIXED_PRIORITY_EN defined, source 0 SHALL win every tie in IDLE, and last_served SHALL be ignored.
REQ-022 Without PCIE_TX_ARB_FIXED_PRIORITY_EN, the round-robin behaviour of REQ-007 SHALL apply.
REQ-023 Hold and counting behaviour SHALL be identical with or without the macro.

Verification
REQ-024 Single source: source 0 sends 4 beats 0x1..0x4 with i_64_ready=1 -> o_grant=01, 4 transfers in order, o_64_last on beat 4, o_s0_pkt_count=1, then o_grant=00.
REQ-025 Tie after reset: both sources valid with 2-beat packets -> source 0 first, then source 1 -> counters 1/1 and grant sequence 01, 00, 10, 00.
REQ-026 Persistent contention: both sources stream 3 packets each -> grants strictly alternate in round-robin; with PCIE_TX_ARB_FIXED_PRIORITY_EN, source 0's 3 packets all precede source 1's.
REQ-027 Backpressure and gap: i_64_ready toggles every cycle and source 1 drops valid for 2 cycles mid-packet -> grant held, no beat lost or duplicated, and source 0 ready stays 0 throughout.
REQ-028 Reset mid-packet: rst asserted after beat 2 of a 5-beat packet -> next cycle o_grant=00 and count=0; the source then resends and the packet completes with count=1.
REQ-029 Wrap: with COUNT_WIDTH=2, source 0 sends 5 one-beat packets -> o_s0_pkt_count reads 1, 2, 3, 0, 1.
